port_arbiter: RTL

- Shares one GPIO port block between NREQ requesters (CPU load/store unit, debug/DMA master) and sequences its control strobes.
- Accepts WRITE, READ and SET_DIR requests over a valid/ready handshake.
- Inserts direction changes and bus turnaround automatically, then returns a one-cycle response tagged with the requester id.
- Sits between the requesters and the port's cePortDir/portDir/cePortOut/portData inputs; samples the pin bus for reads.

---
 rtl/port_pkg.sv | 31 +++
 rtl/port_arbiter_if.sv | 25 ++
 rtl/port_arbiter_rr_arbiter.sv | 31 +++
 rtl/port_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/port_pkg.sv
// Shared types and constants for the GPIO port arbiter.
package port_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'd0,
        OP_READ    = 2'd1,
        OP_SETDIR  = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DIR  = 3'd1,
        TURN = 3'd2,
        EXEC = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Direction a request needs the port to be in before it can execute.
    function automatic logic target_dir(op_t op, logic d0);
        logic t;
        t = DIR_IN;
        if (op == OP_SETDIR)     t = d0;
        else if (op == OP_WRITE) t = DIR_OUT;
        return t;
    endfunction

endpackage

// File: rtl/port_arbiter_if.sv
// Requester-side request/response bus of the port arbiter.
interface port_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       reqValid;
    logic [2*NREQ-1:0]     reqOp;
    logic [WIDTH*NREQ-1:0] reqData;
    logic [NREQ-1:0]       reqReady;
    logic                  rspValid;
    logic [IDW-1:0]        rspId;
    logic [WIDTH-1:0]      rspData;

    modport slave (
        input  reqValid, reqOp, reqData,
        output reqReady, rspValid, rspId, rspData
    );

    modport master (
        output reqValid, reqOp, reqData,
        input  reqReady, rspValid, rspId, rspData
    );
endinterface

// File: rtl/port_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);
    logic [IDW:0] cand;
    logic         found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr < NREQ, so one conditional subtract is enough to wrap
            cand = (IDW+1)'(ptr_i) + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
            if (en_i && !found && req_i[cand[IDW-1:0]]) begin
                found                   = 1'b1;
                gnt_o[cand[IDW-1:0]]    = 1'b1;
                idx_o                   = cand[IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/port_arbiter.sv
// Shares one GPIO port between NREQ requesters, sequencing direction
// changes, bus turnaround and the port strobes for each request.
module port_arbiter
    import port_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             rst,
    port_arbiter_if.slave    bus,
    output logic             cePortDir,
    output logic             portDir,
    output logic             cePortOut,
    output logic [WIDTH-1:0] portData,
    input  logic [WIDTH-1:0] portIn,
    output logic             dirState
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] TURN_M1 = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_data;
    logic             tgt;

    // Grants only in IDLE and never during reset, so a requester can't see
    // a transfer that the reset is about to discard.
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req_i (bus.reqValid),
        .ptr_i (ptr_q),
        .en_i  ((state_q == IDLE) && !rst),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    always_comb begin
        sel_op   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_op   = bus.reqOp[2*i +: 2];
                sel_data = bus.reqData[WIDTH*i +: WIDTH];
            end
        end
    end

    assign tgt = target_dir(op_q, data_q[0]);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        op_d       = op_q;
        data_d     = data_q;
        dir_d      = dir_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d   = gnt_idx;
                    op_d   = op_t'(sel_op);
                    data_d = sel_data;
                    ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
                    case (op_t'(sel_op))
                        OP_SETDIR: state_d = DIR;
                        OP_WRITE:  state_d = (dir_q == DIR_IN)  ? DIR : EXEC;
                        OP_READ:   state_d = (dir_q == DIR_OUT) ? DIR : EXEC;
                        default: begin
                            state_d    = RESP;
                            rsp_data_d = '0;
                        end
                    endcase
                end
            end
            DIR: begin
                dir_d = tgt;
                if (op_q == OP_SETDIR) begin
                    state_d    = RESP;
                    rsp_data_d = '0;
                end else if (TURN > 0) begin
                    state_d = port_pkg::TURN;
                    cnt_d   = TURN_M1;
                end else begin
                    state_d = EXEC;
                end
            end
            port_pkg::TURN: begin
                if (cnt_q == 4'd0) state_d = EXEC;
                else               cnt_d   = cnt_q - 4'd1;
            end
            EXEC: begin
                state_d    = RESP;
                rsp_data_d = (op_q == OP_READ) ? portIn : data_q;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            op_q       <= OP_WRITE;
            data_q     <= '0;
            dir_q      <= DIR_IN;
            cnt_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            op_q       <= op_d;
            data_q     <= data_d;
            dir_q      <= dir_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.reqReady = gnt;
    assign bus.rspValid = (state_q == RESP);
    assign bus.rspId    = (state_q == RESP) ? id_q : '0;
    assign bus.rspData  = rsp_data_q;

    assign cePortDir = (state_q == DIR);
    assign portDir   = (state_q == DIR) ? tgt : dir_q;
    assign cePortOut = (state_q == EXEC) && (op_q == OP_WRITE);
    assign portData  = data_q;
    assign dirState  = dir_q;
endmodule
